// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor, then echoes every received byte over the processor bus.
// Rev 1.0 - initial release
`default_nettype none

module spart_driver #(
   parameter logic [15:0] DIV0 = 16'h0515,
   parameter logic [15:0] DIV1 = 16'h028A,
   parameter logic [15:0] DIV2 = 16'h0145,
   parameter logic [15:0] DIV3 = 16'h00A2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       cfg_done,
   output logic [7:0] last_byte,
   output logic [7:0] echo_cnt
);

   typedef enum logic [3:0] {
      CFG_LO_SETUP = 4'd0,
      CFG_LO       = 4'd1,
      CFG_HI_SETUP = 4'd2,
      CFG_HI       = 4'd3,
      POLL         = 4'd4,
      RD1          = 4'd5,
      RD2          = 4'd6,
      WAIT_TBR     = 4'd7,
      TX_SETUP     = 4'd8,
      TX           = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sync1_q, cfg_q, cfg_lat_q;
   logic        reconfig;
   logic        iocs_q, iorw_q, drive_q, rd2_q;
   logic        iocs_d, iorw_d, drive_d, rd2_d;
   logic [1:0]  ioaddr_q, ioaddr_d;
   logic [7:0]  dout_q, dout_d;
   logic        cfg_done_q;
   logic [7:0]  last_byte_q, echo_cnt_q;
   logic [15:0] div_now, div_lat;

   function automatic logic [15:0] div_of(input logic [1:0] sel);
      case (sel)
         2'b00:   div_of = DIV0;
         2'b01:   div_of = DIV1;
         2'b10:   div_of = DIV2;
         default: div_of = DIV3;
      endcase
   endfunction

   assign div_now = div_of(cfg_q);
   assign div_lat = div_of(cfg_lat_q);

   // Switch synchroniser runs through reset so cfg_q is settled when programming starts.
   always_ff @(posedge clk) begin
      sync1_q <= br_cfg;
      cfg_q   <= sync1_q;
   end

   always_comb begin
      state_d  = state_q;
      reconfig = 1'b0;
      case (state_q)
         CFG_LO_SETUP: state_d = CFG_LO;
         CFG_LO:       state_d = CFG_HI_SETUP;
         CFG_HI_SETUP: state_d = CFG_HI;
         CFG_HI:       state_d = POLL;
         POLL: begin
            if (cfg_q != cfg_lat_q) begin
               state_d  = CFG_LO_SETUP;
               reconfig = 1'b1;
            end else if (rda) begin
               state_d = RD1;
            end
         end
         RD1:          state_d = RD2;
         RD2:          state_d = WAIT_TBR;
         WAIT_TBR:     if (tbr) state_d = TX_SETUP;
         TX_SETUP:     state_d = TX;
         TX:           state_d = POLL;
         default:      state_d = CFG_LO_SETUP;
      endcase
   end

   // Bus pins are registered from state_q, so each phase appears on the bus one cycle after the state.
   always_comb begin
      iocs_d   = 1'b0;
      iorw_d   = 1'b1;
      ioaddr_d = 2'b00;
      drive_d  = 1'b0;
      dout_d   = dout_q;
      rd2_d    = (state_q == RD2);
      case (state_q)
         CFG_LO_SETUP: begin iorw_d = 1'b0; ioaddr_d = 2'b10; drive_d = 1'b1; dout_d = div_now[7:0]; end
         CFG_LO:       begin iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b10; drive_d = 1'b1; end
         CFG_HI_SETUP: begin iorw_d = 1'b0; ioaddr_d = 2'b11; drive_d = 1'b1; dout_d = div_lat[15:8]; end
         CFG_HI:       begin iocs_d = 1'b1; iorw_d = 1'b0; ioaddr_d = 2'b11; drive_d = 1'b1; end
         RD1, RD2:     begin iocs_d = 1'b1; end
         TX_SETUP:     begin iorw_d = 1'b0; drive_d = 1'b1; dout_d = last_byte_q; end
         TX:           begin iocs_d = 1'b1; iorw_d = 1'b0; drive_d = 1'b1; end
         default:      ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= CFG_LO_SETUP;
         cfg_lat_q   <= 2'b00;
         iocs_q      <= 1'b0;
         iorw_q      <= 1'b1;
         ioaddr_q    <= 2'b00;
         drive_q     <= 1'b0;
         dout_q      <= 8'h00;
         rd2_q       <= 1'b0;
         cfg_done_q  <= 1'b0;
         last_byte_q <= 8'h00;
         echo_cnt_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         iocs_q   <= iocs_d;
         iorw_q   <= iorw_d;
         ioaddr_q <= ioaddr_d;
         drive_q  <= drive_d;
         dout_q   <= dout_d;
         rd2_q    <= rd2_d;
         if (state_q == CFG_LO_SETUP)
            cfg_lat_q <= cfg_q;
         if (reconfig)
            cfg_done_q <= 1'b0;
         else if (iocs_q && !iorw_q && (ioaddr_q == 2'b11))
            cfg_done_q <= 1'b1;
         if (rd2_q)
            last_byte_q <= databus;
         if (iocs_q && !iorw_q && (ioaddr_q == 2'b00))
            echo_cnt_q <= echo_cnt_q + 8'd1;
      end
   end

   assign databus   = drive_q ? dout_q : 8'hzz;
   assign iocs      = iocs_q;
   assign iorw      = iorw_q;
   assign ioaddr    = ioaddr_q;
   assign cfg_done  = cfg_done_q;
   assign last_byte = last_byte_q;
   assign echo_cnt  = echo_cnt_q;

endmodule

`default_nettype wire
